objects_mux_layered: RTL and testbench
======================================

OBJECTS_MUX_LAYERED -- requirements
Module: objects_mux_layered

Interface
REQ-001 Parameter NUM_LAYERS, default 8, number of drawing layers (2..16).
REQ-002 Parameter RGB_W, default 8, pixel colour width.
REQ-003 Parameter TRANSPARENT, default 8'hFF (RGB_W bits), colour treated as not drawn.
REQ-004 Parameter HIT_REF, default 0, reference layer (ball) for overlap detection.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 resetN  input  1  reset, synchronous, active-low.
REQ-007 frame_start  input  1  one-cycle pulse at first pixel of each frame.
REQ-008 draw_req  input  NUM_LAYERS  per-layer draw request, bit i = layer i.
REQ-009 rgb_in  input  NUM_LAYERS*RGB_W  packed layer colours, layer i at bits [i*RGB_W +: RGB_W].
REQ-010 rgb_background  input  RGB_W  colour when no layer wins.
REQ-011 layer_enable  input  NUM_LAYERS  per-layer enable mask, sampled at frame_start.
REQ-012 cfg_we  input  1  write strobe for shadow priority table.
REQ-013 cfg_slot  input  $clog2(NUM_LAYERS)  priority slot written (0 = highest).
REQ-014 cfg_layer  input  $clog2(NUM_LAYERS)  layer index placed in cfg_slot.
REQ-015 rgb_out  output  RGB_W  muxed screen pixel.
REQ-016 draw_any  output  1  high when some layer won the pixel.
REQ-017 winner_idx  output  $clog2(NUM_LAYERS)  winning layer index; 0 when draw_any low.
REQ-018 hit_flags  output  NUM_LAYERS  layers that overlapped HIT_REF during previous frame.
REQ-019 hit_valid  output  1  one-cycle pulse when hit_flags updates.

Function
REQ-020 Effective draw for layer i SHALL be draw_req[i] & active_enable[i] & (rgb_in layer i != TRANSPARENT).
REQ-021 Stage 1 SHALL register effective draw vector and rgb_in; stage 2 SHALL register selection result; rgb_out/draw_any/winner_idx SHALL reflect inputs of cycle t at cycle t+2.
REQ-022 Winner SHALL be layer in lowest-numbered active slot whose effective draw is 1; none -> rgb_out = rgb_background, draw_any = 0, winner_idx = 0.
REQ-023 A layer listed in multiple slots SHALL take its highest-priority slot; a layer absent from the table SHALL never win.
REQ-024 cfg_we SHALL write shadow[cfg_slot] <= cfg_layer in same cycle; active table unchanged until next frame_start.
REQ-025 On frame_start, active table SHALL load shadow table, including any write in that same cycle; active_enable SHALL load layer_enable.
REQ-026 New active table/enable SHALL apply to the pixel presented on the frame_start cycle.
REQ-027 Overlap accumulator bit i (i != HIT_REF) SHALL set when stage-1 effective draws of layer i and HIT_REF are both 1; bit HIT_REF SHALL stay 0.
REQ-028 On frame_start, hit_flags SHALL load accumulator (terms up to previous cycle) and accumulator SHALL clear, then include the frame_start-cycle term; hit_valid SHALL pulse the cycle after frame_start.
REQ-029 Pipeline SHALL not stall; frame_start and cfg_we SHALL have no handshake and no latency penalty.

Reset
REQ-030 On resetN low at posedge: rgb_out, draw_any, winner_idx, hit_flags, hit_valid, pipeline registers, accumulator SHALL be 0.
REQ-031 Reset SHALL set shadow and active slot i = layer i (fixed priority, layer 0 highest) and active_enable all 1s.
REQ-032 Reset mid-frame SHALL discard accumulated overlaps; first hit_valid after reset SHALL follow the next frame_start.

Structure
REQ-033 Package objects_mux_pkg SHALL hold default NUM_LAYERS, RGB_W, TRANSPARENT, and layer_idx_t typedef.
REQ-034 Combinational priority resolver SHALL be sub-module objects_priority_select (draw vector + table in, winner_idx + found out).

Verification
REQ-035 Reset defaults, layers 0 and 3 drawing 8'h1C/8'hE0 -> two cycles later rgb_out = 8'h1C, winner_idx = 0.
REQ-036 Write slot0 = layer3, slot3 = layer0 mid-frame -> output unchanged until frame_start, then layer 3 (8'hE0) wins from that pixel.
REQ-037 Layer 0 drawing colour 8'hFF, layer 2 drawing 8'h03 -> rgb_out = 8'h03, winner_idx = 2.
REQ-038 layer_enable = 8'hFE at frame_start with layer 0 drawing -> background shown for that frame only.
REQ-039 Layers 0 and 5 overlap 3 pixels in frame N -> at frame N+1 start, hit_flags = 8'h20, hit_valid one pulse; no overlap next frame -> 8'h00.
REQ-040 resetN low mid-frame after overlap -> hit_flags 0, no hit_valid until next frame_start, priority table identity.

Source files
------------

// File: rtl/objects_mux_pkg.sv
// Shared defaults and index type for the layered object multiplexer.
package objects_mux_pkg;

    localparam int unsigned DEF_NUM_LAYERS  = 8;
    localparam int unsigned DEF_RGB_W       = 8;
    localparam logic [7:0]  DEF_TRANSPARENT = 8'hFF;
    localparam int unsigned DEF_IDX_W       = $clog2(DEF_NUM_LAYERS);

    typedef logic [DEF_IDX_W-1:0] layer_idx_t;

endpackage

// File: rtl/objects_priority_select.sv
// Combinational priority resolver: the first table slot whose layer is drawing wins.
module objects_priority_select #(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic [NUM_LAYERS-1:0]            draw_i,
    input  logic [NUM_LAYERS-1:0][IDX_W-1:0] table_i,
    output logic [IDX_W-1:0]                 winner_idx_o,
    output logic                             found_o
);

    logic             hit;
    logic [IDX_W-1:0] win;

    // Ascending scan with a sticky hit flag: a duplicated layer resolves at its best slot.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int unsigned s = 0; s < NUM_LAYERS; s++) begin
            if (!hit && (32'(table_i[s]) < NUM_LAYERS) && draw_i[table_i[s]]) begin
                hit = 1'b1;
                win = table_i[s];
            end
        end
        winner_idx_o = win;
        found_o      = hit;
    end

endmodule

// File: rtl/objects_mux_layered.sv
// Two-stage layered pixel multiplexer with frame-synchronous priority table and overlap flags.
module objects_mux_layered
    import objects_mux_pkg::*;
#(
    parameter int unsigned           NUM_LAYERS  = DEF_NUM_LAYERS,
    parameter int unsigned           RGB_W       = DEF_RGB_W,
    parameter logic [RGB_W-1:0]      TRANSPARENT = RGB_W'(DEF_TRANSPARENT),
    parameter int unsigned           HIT_REF     = 0
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            frame_start,
    input  logic [NUM_LAYERS-1:0]           draw_req,
    input  logic [NUM_LAYERS*RGB_W-1:0]     rgb_in,
    input  logic [RGB_W-1:0]                rgb_background,
    input  logic [NUM_LAYERS-1:0]           layer_enable,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_LAYERS)-1:0]   cfg_slot,
    input  logic [$clog2(NUM_LAYERS)-1:0]   cfg_layer,
    output logic [RGB_W-1:0]                rgb_out,
    output logic                            draw_any,
    output logic [$clog2(NUM_LAYERS)-1:0]   winner_idx,
    output logic [NUM_LAYERS-1:0]           hit_flags,
    output logic                            hit_valid
);

    localparam int unsigned            IDX_W    = $clog2(NUM_LAYERS);
    localparam logic [NUM_LAYERS-1:0]  REF_MASK = NUM_LAYERS'(1) << HIT_REF;

    logic [NUM_LAYERS-1:0][IDX_W-1:0] shadow_q, shadow_d, active_q;
    logic [NUM_LAYERS-1:0]            act_en_q, en_eff, draw_eff;
    logic [NUM_LAYERS-1:0]            d1_q;
    logic [NUM_LAYERS*RGB_W-1:0]      rgb1_q;
    logic [RGB_W-1:0]                 bg1_q;
    logic [NUM_LAYERS-1:0]            acc_q, acc_d, hit_term, hit_flags_q;
    logic                             hit_valid_q;
    logic [RGB_W-1:0]                 rgb_out_q, rgb_sel;
    logic                             draw_any_q, sel_found;
    logic [IDX_W-1:0]                 winner_q, sel_idx;

    // The frame_start pixel already sees the newly sampled enable mask.
    always_comb begin
        en_eff = frame_start ? layer_enable : act_en_q;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            draw_eff[i] = draw_req[i] & en_eff[i] &
                          (rgb_in[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && (32'(cfg_slot) < NUM_LAYERS)) begin
            shadow_d[cfg_slot] = cfg_layer;
        end
    end

    always_comb begin
        hit_term = (d1_q[HIT_REF] ? d1_q : '0) & ~REF_MASK;
        acc_d    = frame_start ? hit_term : (acc_q | hit_term);
    end

    objects_priority_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_select (
        .draw_i       (d1_q),
        .table_i      (active_q),
        .winner_idx_o (sel_idx),
        .found_o      (sel_found)
    );

    always_comb begin
        rgb_sel = bg1_q;
        if (sel_found) begin
            rgb_sel = rgb1_q[32'(sel_idx)*RGB_W +: RGB_W];
        end
    end

    // Table is consumed in stage 2, so loading it at frame_start lines up with that cycle's pixel.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                shadow_q[i] <= IDX_W'(i);
                active_q[i] <= IDX_W'(i);
            end
            act_en_q    <= '1;
            d1_q        <= '0;
            rgb1_q      <= '0;
            bg1_q       <= '0;
            acc_q       <= '0;
            hit_flags_q <= '0;
            hit_valid_q <= 1'b0;
            rgb_out_q   <= '0;
            draw_any_q  <= 1'b0;
            winner_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (frame_start) begin
                active_q    <= shadow_d;
                act_en_q    <= layer_enable;
                hit_flags_q <= acc_q;
            end
            acc_q       <= acc_d;
            hit_valid_q <= frame_start;
            d1_q        <= draw_eff;
            rgb1_q      <= rgb_in;
            bg1_q       <= rgb_background;
            rgb_out_q   <= rgb_sel;
            draw_any_q  <= sel_found;
            winner_q    <= sel_found ? sel_idx : '0;
        end
    end

    assign rgb_out    = rgb_out_q;
    assign draw_any   = draw_any_q;
    assign winner_idx = winner_q;
    assign hit_flags  = hit_flags_q;
    assign hit_valid  = hit_valid_q;

endmodule

// File: tb/tb_objects_mux_layered.sv
// Directed bench for objects_mux_layered with default parameters.
module tb_objects_mux_layered;

    localparam logic [7:0] BG = 8'h5A;

    logic        clk = 1'b0;
    logic        resetN;
    logic        frame_start;
    logic [7:0]  draw_req;
    logic [63:0] rgb_in;
    logic [7:0]  rgb_background;
    logic [7:0]  layer_enable;
    logic        cfg_we;
    logic [2:0]  cfg_slot;
    logic [2:0]  cfg_layer;
    logic [7:0]  rgb_out;
    logic        draw_any;
    logic [2:0]  winner_idx;
    logic [7:0]  hit_flags;
    logic        hit_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    objects_mux_layered dut (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .draw_req       (draw_req),
        .rgb_in         (rgb_in),
        .rgb_background (rgb_background),
        .layer_enable   (layer_enable),
        .cfg_we         (cfg_we),
        .cfg_slot       (cfg_slot),
        .cfg_layer      (cfg_layer),
        .rgb_out        (rgb_out),
        .draw_any       (draw_any),
        .winner_idx     (winner_idx),
        .hit_flags      (hit_flags),
        .hit_valid      (hit_valid)
    );

    typedef struct {
        logic [7:0]  draw;
        logic [63:0] rgb;
        logic [7:0]  exp_rgb;
        logic        exp_any;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] e_rgb,
                             input logic e_any, input logic [2:0] e_idx);
        check({name, ".rgb"}, 32'(rgb_out), 32'(e_rgb));
        check({name, ".any"}, 32'(draw_any), 32'(e_any));
        check({name, ".idx"}, 32'(winner_idx), 32'(e_idx));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        vec_t prev;

        vecs[0] = '{8'h09, 64'hFFFFFFFF_E0FFFF1C, 8'h1C, 1'b1, 3'd0};
        vecs[1] = '{8'h05, 64'hFFFFFFFF_FF03FFFF, 8'h03, 1'b1, 3'd2};
        vecs[2] = '{8'h00, 64'hFFFFFFFF_E0FFFF1C, BG,    1'b0, 3'd0};
        vecs[3] = '{8'hFF, 64'hFFFFFFFF_FFFFFFFF, BG,    1'b0, 3'd0};
        vecs[4] = '{8'h80, 64'h77FFFFFF_FFFFFFFF, 8'h77, 1'b1, 3'd7};
        vecs[5] = '{8'hC0, 64'h7766FFFF_FFFFFFFF, 8'h66, 1'b1, 3'd6};
        vecs[6] = '{8'h00, 64'h01020304_05060708, BG,    1'b0, 3'd0};
        vecs[7] = '{8'h06, 64'hFFFFFFFF_FF2211FF, 8'h11, 1'b1, 3'd1};

        resetN = 1'b0; frame_start = 1'b0; draw_req = 8'h09;
        rgb_in = 64'hFFFFFFFF_E0FFFF1C; rgb_background = BG; layer_enable = 8'hFF;
        cfg_we = 1'b0; cfg_slot = '0; cfg_layer = '0;
        step(); step(); step();
        check_out("reset", 8'h00, 1'b0, 3'd0);
        check("reset.hit_flags", 32'(hit_flags), 32'h0);
        check("reset.hit_valid", 32'(hit_valid), 32'h0);

        resetN = 1'b1;
        draw_req = 8'h00;
        step(); step();
        prev = '{8'h00, 64'h0, BG, 1'b0, 3'd0};
        for (int i = 0; i < 8; i++) begin
            draw_req = vecs[i].draw;
            rgb_in   = vecs[i].rgb;
            step();
            check_out($sformatf("vec%0d.latency", i), prev.exp_rgb, prev.exp_any, prev.exp_idx);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_rgb, vecs[i].exp_any, vecs[i].exp_idx);
            prev = vecs[i];
        end

        // Shadow writes mid-frame, activated at frame_start.
        draw_req = 8'h09; rgb_in = 64'hFFFFFFFF_E0FFFF1C;
        step(); step();
        check_out("pre_cfg", 8'h1C, 1'b1, 3'd0);
        cfg_we = 1'b1; cfg_slot = 3'd0; cfg_layer = 3'd3;
        step();
        cfg_slot = 3'd3; cfg_layer = 3'd0;
        step();
        cfg_we = 1'b0;
        step(); step();
        check_out("cfg_shadow_only", 8'h1C, 1'b1, 3'd0);
        pulse_frame();
        check_out("fs_prev_pixel", 8'h1C, 1'b1, 3'd0);
        step();
        check_out("fs_new_table", 8'hE0, 1'b1, 3'd3);

        cfg_we = 1'b1; cfg_slot = 3'd0; cfg_layer = 3'd0;
        pulse_frame();
        cfg_we = 1'b0;
        step();
        check_out("fs_same_cycle_write", 8'h1C, 1'b1, 3'd0);
        draw_req = 8'h08;
        step(); step();
        check_out("absent_layer", BG, 1'b0, 3'd0);
        cfg_we = 1'b1; cfg_slot = 3'd3; cfg_layer = 3'd3;
        step();
        cfg_we = 1'b0;
        pulse_frame();
        step(); step();
        check_out("restored", 8'hE0, 1'b1, 3'd3);

        // Enable mask applies for exactly one frame.
        draw_req = 8'h01; rgb_in = 64'hFFFFFFFF_FFFFFF1C;
        step(); step();
        layer_enable = 8'hFE;
        pulse_frame();
        layer_enable = 8'hFF;
        check_out("en_prev_pixel", 8'h1C, 1'b1, 3'd0);
        step();
        check_out("en_masked", BG, 1'b0, 3'd0);
        step(); step(); step();
        check_out("en_masked_hold", BG, 1'b0, 3'd0);
        pulse_frame();
        step();
        check_out("en_restored", 8'h1C, 1'b1, 3'd0);

        // Overlap flags.
        draw_req = 8'h00;
        step(); step();
        pulse_frame();
        check("hv_pulse0", 32'(hit_valid), 32'h1);
        step();
        check("hv_single", 32'(hit_valid), 32'h0);
        draw_req = 8'h21; rgb_in = 64'hFFFF55FF_FFFFFF1C;
        step(); step();
        check_out("overlap_win", 8'h1C, 1'b1, 3'd0);
        step();
        draw_req = 8'h00;
        step(); step(); step();
        check("no_hv_midframe", 32'(hit_valid), 32'h0);
        pulse_frame();
        check("hit_valid_n1", 32'(hit_valid), 32'h1);
        check("hit_flags_n1", 32'(hit_flags), 32'h20);
        step();
        check("hit_valid_drop", 32'(hit_valid), 32'h0);
        check("hit_flags_hold", 32'(hit_flags), 32'h20);
        draw_req = 8'h21; rgb_in = 64'hFFFFFFFF_FFFFFF1C;
        step(); step(); step();
        draw_req = 8'h01;
        step(); step(); step();
        pulse_frame();
        check("hit_valid_n2", 32'(hit_valid), 32'h1);
        check("hit_flags_n2", 32'(hit_flags), 32'h00);

        // Reset mid-frame after overlap with a non-identity table.
        cfg_we = 1'b1; cfg_slot = 3'd0; cfg_layer = 3'd5;
        step();
        cfg_we = 1'b0;
        pulse_frame();
        draw_req = 8'h21; rgb_in = 64'hFFFF55FF_FFFFFF1C;
        step(); step();
        check_out("pre_reset_table", 8'h55, 1'b1, 3'd5);
        step();
        draw_req = 8'h00;
        step();
        resetN = 1'b0;
        step();
        check_out("rst_mid", 8'h00, 1'b0, 3'd0);
        check("rst_mid.hit_flags", 32'(hit_flags), 32'h0);
        check("rst_mid.hit_valid", 32'(hit_valid), 32'h0);
        resetN = 1'b1;
        step(); step(); step(); step();
        check("rst_no_hv", 32'(hit_valid), 32'h0);
        pulse_frame();
        check("rst_hv_after_fs", 32'(hit_valid), 32'h1);
        check("rst_discard", 32'(hit_flags), 32'h00);
        step();
        draw_req = 8'h21;
        step(); step();
        check_out("rst_identity", 8'h1C, 1'b1, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
